any1_bitfield_seq: RTL and testbench
====================================

ANY1_BITFIELD_SEQ -- requirements
Module: any1_bitfield_seq

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, operand/result width.
REQ-002 SHALL have parameter TAGW, default 5, request tag width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush_i, input, 1, abort of the in-flight operation.
REQ-006 SHALL have ports req_valid_i[1:0] and req_ready_o[1:0], input/output, 1 each per requester, request handshake.
REQ-007 SHALL have ports req_op_i[r], input, 3, bitfield opcode per requester r.
REQ-008 SHALL have ports req_a_i, req_b_i, req_c_i, req_d_i per requester, input, DWIDTH each; c = start bit, d = length-1.
REQ-009 SHALL have port req_tag_i[r], input, TAGW, per-requester tag.
REQ-010 SHALL have ports rsp_valid_o (output, 1) and rsp_ready_i (input, 1), response handshake.
REQ-011 SHALL have port rsp_data_o, output, DWIDTH, result.
REQ-012 SHALL have ports rsp_tag_o (output, TAGW) and rsp_src_o (output, 1), echoed tag and granted requester index.
REQ-013 SHALL have port rsp_err_o, output, 1, illegal opcode flag.
REQ-014 SHALL have port done_cnt_o, output, 32, count of completed responses.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, RESP.
REQ-016 In IDLE with no flush_i, the arbiter SHALL assert req_ready_o for exactly one valid requester; req_ready_o SHALL be 0 in EXEC and RESP.
REQ-017 Arbitration SHALL be round-robin: with both requests valid, grant the requester not granted last; with one valid, grant it.
REQ-018 On a handshake, op, a, b, c, d, tag and src SHALL be registered, and the FSM SHALL go to EXEC.
REQ-019 In EXEC, the registered operands SHALL drive the datapath with inst[63:61]=op and all other inst bits 0; the result SHALL be registered, and the FSM SHALL go to RESP.
REQ-020 In RESP, rsp_valid_o SHALL be 1, with data, tag, src and err held stable until rsp_ready_i=1; the FSM then SHALL go to IDLE, done_cnt_o SHALL increment, and last-grant SHALL update.
REQ-021 Latency SHALL be handshake in cycle N, rsp_valid_o first high in cycle N+2; throughput SHALL be at most one op per 3 cycles.
REQ-022 Opcode 3'd7 SHALL produce rsp_data_o=0 and rsp_err_o=1; all other opcodes SHALL give rsp_err_o=0.
REQ-023 flush_i in EXEC or RESP SHALL return the FSM to IDLE next cycle with no response and no count increment.
REQ-024 flush_i in IDLE SHALL block any grant that cycle; flush SHALL take priority over handshake and over rsp_ready_i.
REQ-025 done_cnt_o SHALL wrap from 32'hFFFFFFFF to 0.
REQ-026 Requester inputs that change while req_ready_o=0 SHALL have no effect.

Reset
REQ-027 rst_ni low SHALL, asynchronously: set the FSM to IDLE; force rsp_valid_o=0, rsp_data_o=0, rsp_tag_o=0, rsp_src_o=0, rsp_err_o=0 and done_cnt_o=0; and set last-grant=1, so requester 0 wins first.
REQ-028 Reset asserted mid-operation SHALL discard the operation with no response after release.

Structure
REQ-029 The opcode constants (BFSET=0 … BFFFO=6, illegal=7), the FSM state enum and TAGW default SHALL live in package any1_bitfield_pkg.
REQ-030 The block SHALL instantiate any1_bitfield once as its only sub-module; no datapath logic SHALL be duplicated.

Verification
REQ-031 Req0 BFSET, a=0, c=4, d=3 -> rsp_data_o=64'h00000000000000F0, src=0, valid at N+2.
REQ-032 Req1 BFEXTU, a=64'h12345678, b=0, c=8, d=7, tag=5'h1A -> data=64'h56, tag=5'h1A; BFEXT, a=64'h8000, c=8, d=7 -> data=64'hFFFFFFFFFFFFFF80.
REQ-033 Both requesters held valid for 4 ops -> grants 0,1,0,1; done_cnt_o=4.
REQ-034 rsp_ready_i low 5 cycles in RESP -> outputs stable, req_ready_o=0 throughout, one count increment.
REQ-035 flush_i pulsed in EXEC -> no rsp_valid_o, done_cnt_o unchanged, next request accepted the following cycle.
REQ-036 Opcode 3'd7 -> data=0, err=1; rst_ni low during RESP -> rsp_valid_o=0 immediately, done_cnt_o=0.

Source files
------------

// File: rtl/any1_bitfield_pkg.sv
// -----------------------------------------------------------------------------
// any1_bitfield_pkg
// Shared definitions for the sequenced bitfield unit:
//   - bitfield opcode encodings (instruction bits [63:61])
//   - FSM state encoding of the sequencer
//   - default request tag width
//   - helper that builds the instruction word fed to the datapath
// -----------------------------------------------------------------------------
package any1_bitfield_pkg;

    localparam int TAGW_DEF = 5;

    // Bitfield opcodes
    localparam logic [2:0] OP_BFSET   = 3'd0;   // set field bits
    localparam logic [2:0] OP_BFCLR   = 3'd1;   // clear field bits
    localparam logic [2:0] OP_BFCHG   = 3'd2;   // invert field bits
    localparam logic [2:0] OP_BFINS   = 3'd3;   // insert low bits of b into field
    localparam logic [2:0] OP_BFEXTU  = 3'd4;   // extract field, zero-extended
    localparam logic [2:0] OP_BFEXT   = 3'd5;   // extract field, sign-extended
    localparam logic [2:0] OP_BFFFO   = 3'd6;   // index of highest set bit in field
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Instruction word for the datapath: opcode in the top three bits, rest zero.
    function automatic logic [63:0] make_inst(input logic [2:0] op);
        make_inst = {op, 61'd0};
    endfunction

endpackage

// File: rtl/any1_bitfield_seq_if.sv
// -----------------------------------------------------------------------------
// any1_bitfield_seq_if
// Request/response bundle of the sequenced bitfield unit.
//   Request side (two requesters, index r = 0/1):
//     req_valid_i[r], req_ready_o[r]  handshake
//     req_op_i[r]                      3-bit opcode
//     req_a_i/b_i/c_i/d_i[r]           operands (c = start bit, d = length-1)
//     req_tag_i[r]                     tag echoed on the response
//   Response side:
//     rsp_valid_o, rsp_ready_i         handshake
//     rsp_data_o, rsp_tag_o, rsp_src_o, rsp_err_o
//   Status:
//     done_cnt_o                       completed-response counter
// Modports: slave = the unit, master = requesters / response consumer.
// -----------------------------------------------------------------------------
interface any1_bitfield_seq_if
    import any1_bitfield_pkg::*;
#(
    parameter int DWIDTH = 64,
    parameter int TAGW   = TAGW_DEF
);

    logic [1:0]                  req_valid_i;
    logic [1:0]                  req_ready_o;
    logic [1:0][2:0]             req_op_i;
    logic [1:0][DWIDTH-1:0]      req_a_i;
    logic [1:0][DWIDTH-1:0]      req_b_i;
    logic [1:0][DWIDTH-1:0]      req_c_i;
    logic [1:0][DWIDTH-1:0]      req_d_i;
    logic [1:0][TAGW-1:0]        req_tag_i;

    logic                        rsp_valid_o;
    logic                        rsp_ready_i;
    logic [DWIDTH-1:0]           rsp_data_o;
    logic [TAGW-1:0]             rsp_tag_o;
    logic                        rsp_src_o;
    logic                        rsp_err_o;

    logic [31:0]                 done_cnt_o;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, req_c_i, req_d_i, req_tag_i,
        input  rsp_ready_i,
        output req_ready_o,
        output rsp_valid_o, rsp_data_o, rsp_tag_o, rsp_src_o, rsp_err_o,
        output done_cnt_o
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, req_c_i, req_d_i, req_tag_i,
        output rsp_ready_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_data_o, rsp_tag_o, rsp_src_o, rsp_err_o,
        input  done_cnt_o
    );

endinterface

// File: rtl/any1_bitfield.sv
// -----------------------------------------------------------------------------
// any1_bitfield
// Purely combinational bitfield datapath.
//   inst  : instruction word, opcode in inst[63:61], other bits ignored
//   a     : source operand
//   b     : insert value (BFINS)
//   c     : field start bit (low log2(DWIDTH) bits used)
//   d     : field length minus one (low log2(DWIDTH) bits used)
//   o     : result; zero for the illegal opcode
// A field running past the MSB is truncated at the MSB.
// BFFFO returns all ones when the field holds no set bit.
// -----------------------------------------------------------------------------
module any1_bitfield
    import any1_bitfield_pkg::*;
#(
    parameter int DWIDTH = 64
) (
    input  logic [63:0]       inst,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic [DWIDTH-1:0] c,
    input  logic [DWIDTH-1:0] d,
    output logic [DWIDTH-1:0] o
);

    localparam int IW = $clog2(DWIDTH);
    // One extra bit so start+length never overflows the comparison.
    localparam int EW = IW + 1;

    logic [2:0]        op;
    logic [IW-1:0]     c_idx;
    logic [IW-1:0]     d_idx;
    logic [EW-1:0]     c_ext;
    logic [EW-1:0]     d_ext;
    logic [EW-1:0]     f_end;
    logic [DWIDTH-1:0] fmask;     // field position inside a
    logic [DWIDTH-1:0] lmask;     // field length, right aligned
    logic [DWIDTH-1:0] shifted;   // a with the field moved to bit 0
    logic [DWIDTH-1:0] ins_src;   // b moved up to the field position
    logic [DWIDTH-1:0] ext_s;     // sign-extended extract
    logic [DWIDTH-1:0] fld;
    logic [DWIDTH-1:0] ffo_val;
    logic              unused_bits;

    assign op      = inst[63:61];
    assign c_idx   = c[IW-1:0];
    assign d_idx   = d[IW-1:0];
    assign c_ext   = {1'b0, c_idx};
    assign d_ext   = {1'b0, d_idx};
    assign f_end   = c_ext + d_ext;
    assign shifted = a >> c_idx;
    assign ins_src = b << c_idx;
    assign fld     = a & fmask;

    assign unused_bits = ^{inst[60:0], c[DWIDTH-1:IW], d[DWIDTH-1:IW]};

    generate
        for (genvar gi = 0; gi < DWIDTH; gi++) begin : g_bit
            assign fmask[gi] = (EW'(gi) >= c_ext) && (EW'(gi) <= f_end);
            assign lmask[gi] = (EW'(gi) <= d_ext);
            // Above the field length every bit copies the field's top bit.
            assign ext_s[gi] = lmask[gi] ? shifted[gi] : shifted[d_idx];
        end
    endgenerate

    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        ffo_val = '1;
        for (int i = 0; i < DWIDTH; i++) begin
            if (fld[i]) begin
                ffo_val = DWIDTH'(i);
            end
        end
    end

    always_comb begin
        o = '0;
        case (op)
            OP_BFSET:  o = a | fmask;
            OP_BFCLR:  o = a & ~fmask;
            OP_BFCHG:  o = a ^ fmask;
            OP_BFINS:  o = (a & ~fmask) | (ins_src & fmask);
            OP_BFEXTU: o = shifted & lmask;
            OP_BFEXT:  o = ext_s;
            OP_BFFFO:  o = ffo_val;
            default:   o = '0;
        endcase
    end

endmodule

// File: rtl/any1_bitfield_seq.sv
// -----------------------------------------------------------------------------
// any1_bitfield_seq
// Two-requester front end around the bitfield datapath.
//   clk_i   : clock, all state on the rising edge
//   rst_ni  : asynchronous active-low reset
//   flush_i : abandons the operation in flight; blocks grants while high
//   bus     : request/response bundle (slave modport)
// Sequence: IDLE (round-robin grant, operands captured) -> EXEC (datapath
// result captured) -> RESP (response held until accepted). A request
// handshaken in cycle N shows rsp_valid_o in cycle N+2.
// -----------------------------------------------------------------------------
module any1_bitfield_seq
    import any1_bitfield_pkg::*;
#(
    parameter int DWIDTH = 64,
    parameter int TAGW   = TAGW_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    any1_bitfield_seq_if.slave   bus
);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] EXEC = 2'(ST_EXEC);
    localparam logic [1:0] RESP = 2'(ST_RESP);

    logic [1:0]        state_reg;
    logic [1:0]        state_next;

    logic [2:0]        op_reg;
    logic [DWIDTH-1:0] a_reg;
    logic [DWIDTH-1:0] b_reg;
    logic [DWIDTH-1:0] c_reg;
    logic [DWIDTH-1:0] d_reg;
    logic [TAGW-1:0]   tag_reg;
    logic              src_reg;
    logic [DWIDTH-1:0] data_reg;
    logic              err_reg;
    logic [31:0]       cnt_reg;
    logic [31:0]       cnt_next;
    logic              last_grant_reg;

    logic              grant;
    logic              grant_valid;
    logic              rsp_done;
    logic [63:0]       inst;
    logic [DWIDTH-1:0] bf_result;

    // ------------------------------------------------------------------
    // Round-robin arbiter, only active in IDLE and never during a flush.
    // ------------------------------------------------------------------
    always_comb begin
        grant       = 1'b0;
        grant_valid = 1'b0;
        if (state_reg == IDLE && !flush_i) begin
            case (bus.req_valid_i)
                2'b11: begin
                    grant       = ~last_grant_reg;
                    grant_valid = 1'b1;
                end
                2'b10: begin
                    grant       = 1'b1;
                    grant_valid = 1'b1;
                end
                2'b01: begin
                    grant       = 1'b0;
                    grant_valid = 1'b1;
                end
                default: begin
                    grant       = 1'b0;
                    grant_valid = 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign bus.req_ready_o[gi] = grant_valid && (grant == 1'(gi));
        end
    endgenerate

    // Flush wins over both the request and the response handshake.
    assign rsp_done = (state_reg == RESP) && !flush_i && bus.rsp_ready_i;
    assign cnt_next = cnt_reg + 32'd1;

    always_comb begin
        state_next = state_reg;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (grant_valid) state_next = EXEC;
                EXEC:    state_next = RESP;
                RESP:    if (bus.rsp_ready_i) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: single shared instance, fed from the captured operands.
    // ------------------------------------------------------------------
    assign inst = make_inst(op_reg);

    any1_bitfield #(
        .DWIDTH (DWIDTH)
    ) u_bitfield (
        .inst (inst),
        .a    (a_reg),
        .b    (b_reg),
        .c    (c_reg),
        .d    (d_reg),
        .o    (bf_result)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            op_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            c_reg          <= '0;
            d_reg          <= '0;
            tag_reg        <= '0;
            src_reg        <= 1'b0;
            data_reg       <= '0;
            err_reg        <= 1'b0;
            cnt_reg        <= '0;
            // Requester 1 counts as last served, so requester 0 wins first.
            last_grant_reg <= 1'b1;
        end else begin
            state_reg <= state_next;

            if (grant_valid) begin
                op_reg  <= bus.req_op_i[grant];
                a_reg   <= bus.req_a_i[grant];
                b_reg   <= bus.req_b_i[grant];
                c_reg   <= bus.req_c_i[grant];
                d_reg   <= bus.req_d_i[grant];
                tag_reg <= bus.req_tag_i[grant];
                src_reg <= grant;
            end

            if (state_reg == EXEC && !flush_i) begin
                data_reg <= bf_result;
                err_reg  <= (op_reg == OP_ILLEGAL);
            end

            // Counter wraps naturally at 2^32.
            if (rsp_done) begin
                cnt_reg        <= cnt_next;
                last_grant_reg <= src_reg;
            end
        end
    end

    assign bus.rsp_valid_o = (state_reg == RESP);
    assign bus.rsp_data_o  = data_reg;
    assign bus.rsp_tag_o   = tag_reg;
    assign bus.rsp_src_o   = src_reg;
    assign bus.rsp_err_o   = err_reg;
    assign bus.done_cnt_o  = cnt_reg;

endmodule

// File: tb/tb_any1_bitfield_seq.sv
// -----------------------------------------------------------------------------
// tb_any1_bitfield_seq
// Directed bench for any1_bitfield_seq. Inputs change 1 time unit after the
// rising edge; outputs are sampled there or on the falling edge.
// -----------------------------------------------------------------------------
module tb_any1_bitfield_seq;
    import any1_bitfield_pkg::*;

    logic clk_i;
    logic rst_ni;
    logic flush_i;

    int          n_chk;
    int          n_pass;
    logic [31:0] exp_cnt;

    any1_bitfield_seq_if #(.DWIDTH(64), .TAGW(5)) bus ();

    any1_bitfield_seq #(
        .DWIDTH (64),
        .TAGW   (5)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %-24s got %h", name, obs);
        end else begin
            $display("FAIL %-24s got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic present(input int r, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] c, input logic [63:0] d,
                           input logic [4:0] tag);
        bus.req_op_i[r]    = op;
        bus.req_a_i[r]     = a;
        bus.req_b_i[r]     = b;
        bus.req_c_i[r]     = c;
        bus.req_d_i[r]     = d;
        bus.req_tag_i[r]   = tag;
        bus.req_valid_i[r] = 1'b1;
    endtask

    // Returns 1 time unit after the handshake edge (cycle N+1).
    task automatic wait_grant(input int r);
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk_i);
            if (bus.req_ready_o[r]) got = 1'b1;
            else begin
                @(posedge clk_i); #1;
            end
        end
        check("grant_seen", 64'(got), 64'd1);
        @(posedge clk_i); #1;
        bus.req_valid_i[r] = 1'b0;
    endtask

    // Called in cycle N+1; checks latency, response fields, and the count.
    task automatic finish_op(input string name, input logic [63:0] exp_data,
                             input logic exp_err, input logic exp_src, input logic [4:0] exp_tag);
        check({name, "/n1_valid"}, 64'(bus.rsp_valid_o), 64'd0);
        @(posedge clk_i); #1;
        check({name, "/n2_valid"}, 64'(bus.rsp_valid_o), 64'd1);
        check({name, "/data"},     bus.rsp_data_o,       exp_data);
        check({name, "/err"},      64'(bus.rsp_err_o),   64'(exp_err));
        check({name, "/src"},      64'(bus.rsp_src_o),   64'(exp_src));
        check({name, "/tag"},      64'(bus.rsp_tag_o),   64'(exp_tag));
        bus.rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        bus.rsp_ready_i = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        check({name, "/cnt"},      64'(bus.done_cnt_o),  64'(exp_cnt));
        check({name, "/idle"},     64'(bus.rsp_valid_o), 64'd0);
    endtask

    task automatic run_op(input string name, input int r, input logic [2:0] op,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                          input logic [63:0] d, input logic [4:0] tag,
                          input logic [63:0] exp_data, input logic exp_err);
        present(r, op, a, b, c, d, tag);
        wait_grant(r);
        finish_op(name, exp_data, exp_err, 1'(r), tag);
    endtask

    initial begin
        int          got;
        logic        rr_src [4];
        logic [63:0] rr_dat [4];

        n_chk  = 0;
        n_pass = 0;
        exp_cnt = 32'd0;
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        bus.req_valid_i = '0;
        bus.req_op_i    = '0;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        bus.req_c_i     = '0;
        bus.req_d_i     = '0;
        bus.req_tag_i   = '0;
        bus.rsp_ready_i = 1'b0;

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk_i);
        #1;
        check("rst/valid", 64'(bus.rsp_valid_o), 64'd0);
        check("rst/data",  bus.rsp_data_o,       64'd0);
        check("rst/tag",   64'(bus.rsp_tag_o),   64'd0);
        check("rst/src",   64'(bus.rsp_src_o),   64'd0);
        check("rst/err",   64'(bus.rsp_err_o),   64'd0);
        check("rst/cnt",   64'(bus.done_cnt_o),  64'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // ---------------- round robin, both held valid ----------------
        rr_src[0] = 1'b0; rr_src[1] = 1'b1; rr_src[2] = 1'b0; rr_src[3] = 1'b1;
        rr_dat[0] = 64'h1; rr_dat[1] = 64'hB; rr_dat[2] = 64'h1; rr_dat[3] = 64'hB;
        present(0, OP_BFSET,  64'h0,  64'h0, 64'd0, 64'd0, 5'h01);
        present(1, OP_BFEXTU, 64'hAB, 64'h0, 64'd0, 64'd3, 5'h02);
        bus.rsp_ready_i = 1'b1;
        got = 0;
        for (int k = 0; k < 40 && got < 4; k++) begin
            @(posedge clk_i); #1;
            if (bus.rsp_valid_o) begin
                check($sformatf("rr%0d/src", got),  64'(bus.rsp_src_o), 64'(rr_src[got]));
                check($sformatf("rr%0d/data", got), bus.rsp_data_o,     rr_dat[got]);
                got++;
                if (got == 4) bus.req_valid_i = 2'b00;
            end
        end
        check("rr/count_seen", 64'(got), 64'd4);
        @(posedge clk_i); #1;
        bus.rsp_ready_i = 1'b0;
        exp_cnt = 32'd4;
        check("rr/cnt",   64'(bus.done_cnt_o),  64'(exp_cnt));
        check("rr/valid", 64'(bus.rsp_valid_o), 64'd0);

        // ---------------- directed operations ----------------
        run_op("bfset",      0, OP_BFSET,  64'h0, 64'h0, 64'd4, 64'd3, 5'h03,
               64'h00000000000000F0, 1'b0);
        run_op("bfextu",     1, OP_BFEXTU, 64'h12345678, 64'h0, 64'd8, 64'd7, 5'h1A,
               64'h56, 1'b0);
        run_op("bfext",      1, OP_BFEXT,  64'h8000, 64'h0, 64'd8, 64'd7, 5'h04,
               64'hFFFFFFFFFFFFFF80, 1'b0);
        run_op("bfclr",      0, OP_BFCLR,  64'hFFFFFFFFFFFFFFFF, 64'h0, 64'd0, 64'd7, 5'h05,
               64'hFFFFFFFFFFFFFF00, 1'b0);
        run_op("bfchg",      1, OP_BFCHG,  64'hFF, 64'h0, 64'd4, 64'd7, 5'h06,
               64'hF0F, 1'b0);
        run_op("bfins",      0, OP_BFINS,  64'hFFFF, 64'hA, 64'd4, 64'd3, 5'h07,
               64'hFFAF, 1'b0);
        run_op("bfffo",      1, OP_BFFFO,  64'h1234, 64'h0, 64'd0, 64'd63, 5'h08,
               64'd12, 1'b0);
        run_op("bfffo_none", 0, OP_BFFFO,  64'hF, 64'h0, 64'd8, 64'd7, 5'h09,
               64'hFFFFFFFFFFFFFFFF, 1'b0);
        run_op("bfset_full", 1, OP_BFSET,  64'h0, 64'h0, 64'd0, 64'd63, 5'h0A,
               64'hFFFFFFFFFFFFFFFF, 1'b0);
        run_op("bfset_top",  0, OP_BFSET,  64'h0, 64'h0, 64'd60, 64'd7, 5'h0B,
               64'hF000000000000000, 1'b0);
        run_op("bfextu_top", 1, OP_BFEXTU, 64'hF000000000000000, 64'h0, 64'd60, 64'd7, 5'h0C,
               64'hF, 1'b0);
        run_op("illegal",    0, OP_ILLEGAL, 64'h1234, 64'h55, 64'd4, 64'd3, 5'h0D,
               64'h0, 1'b1);

        // ---------------- response stall ----------------
        present(0, OP_BFSET, 64'h0, 64'h0, 64'd8, 64'd7, 5'h0E);
        wait_grant(0);
        @(posedge clk_i); #1;
        present(1, OP_BFCLR, 64'hFFFF, 64'h0, 64'd0, 64'd3, 5'h11);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d/valid", k), 64'(bus.rsp_valid_o), 64'd1);
            check($sformatf("stall%0d/data", k),  bus.rsp_data_o,       64'hFF00);
            check($sformatf("stall%0d/tag", k),   64'(bus.rsp_tag_o),   64'h0E);
            check($sformatf("stall%0d/ready", k), 64'(bus.req_ready_o), 64'd0);
            check($sformatf("stall%0d/cnt", k),   64'(bus.done_cnt_o),  64'(exp_cnt));
            // Requester 0 operands change while not ready; must not disturb.
            bus.req_a_i[0]   = 64'(k) * 64'h1111;
            bus.req_tag_i[0] = 5'(k);
            @(posedge clk_i); #1;
        end
        bus.req_valid_i[1] = 1'b0;
        bus.rsp_ready_i    = 1'b1;
        @(posedge clk_i); #1;
        bus.rsp_ready_i = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        check("stall/cnt",   64'(bus.done_cnt_o),  64'(exp_cnt));
        check("stall/valid", 64'(bus.rsp_valid_o), 64'd0);

        // ---------------- flush in EXEC ----------------
        present(0, OP_BFSET, 64'h0, 64'h0, 64'd0, 64'd3, 5'h12);
        wait_grant(0);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush_exec/valid", 64'(bus.rsp_valid_o), 64'd0);
        check("flush_exec/cnt",   64'(bus.done_cnt_o),  64'(exp_cnt));
        present(1, OP_BFEXTU, 64'h12345678, 64'h0, 64'd8, 64'd7, 5'h13);
        @(negedge clk_i);
        check("flush_exec/next_ready", 64'(bus.req_ready_o), 64'b10);
        @(posedge clk_i); #1;
        bus.req_valid_i[1] = 1'b0;
        finish_op("after_flush", 64'h56, 1'b0, 1'b1, 5'h13);

        // ---------------- flush in IDLE blocks grant ----------------
        present(0, OP_BFSET, 64'h0, 64'h0, 64'd1, 64'd0, 5'h14);
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_idle/ready", 64'(bus.req_ready_o), 64'd0);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush_idle/valid", 64'(bus.rsp_valid_o), 64'd0);
        wait_grant(0);
        finish_op("after_idle_flush", 64'h2, 1'b0, 1'b0, 5'h14);

        // ---------------- flush in RESP beats rsp_ready ----------------
        present(1, OP_BFSET, 64'h0, 64'h0, 64'd2, 64'd0, 5'h15);
        wait_grant(1);
        @(posedge clk_i); #1;
        check("flush_resp/valid_before", 64'(bus.rsp_valid_o), 64'd1);
        flush_i         = 1'b1;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i         = 1'b0;
        bus.rsp_ready_i = 1'b0;
        check("flush_resp/valid", 64'(bus.rsp_valid_o), 64'd0);
        check("flush_resp/cnt",   64'(bus.done_cnt_o),  64'(exp_cnt));

        // ---------------- reset during RESP ----------------
        present(0, OP_BFSET, 64'h0, 64'h0, 64'd0, 64'd7, 5'h16);
        wait_grant(0);
        @(posedge clk_i); #1;
        check("rst_resp/valid_before", 64'(bus.rsp_valid_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        exp_cnt = 32'd0;
        check("rst_resp/valid", 64'(bus.rsp_valid_o), 64'd0);
        check("rst_resp/cnt",   64'(bus.done_cnt_o),  64'(exp_cnt));
        check("rst_resp/data",  bus.rsp_data_o,       64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            check($sformatf("rst_resp/quiet%0d", k), 64'(bus.rsp_valid_o), 64'd0);
        end
        // Last completion before the reset was requester 0; reset must make 0 win again.
        present(0, OP_BFSET,  64'h0, 64'h0, 64'd4, 64'd3, 5'h17);
        present(1, OP_BFEXTU, 64'h0, 64'h0, 64'd0, 64'd0, 5'h18);
        @(negedge clk_i);
        check("rst_resp/first_grant", 64'(bus.req_ready_o), 64'b01);
        @(posedge clk_i); #1;
        bus.req_valid_i = 2'b00;
        finish_op("after_reset", 64'hF0, 1'b0, 1'b0, 5'h17);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
